// File: rtl/debug_ctrl.sv
// Debug controller: accepts host commands to load a byte-wide code ROM, manage
// PC breakpoints, and run or single-step the CPU, reporting each completion as
// a one-cycle response pulse.
module debug_ctrl #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned NUM_BYTES = 512,
    parameter int unsigned NUM_BP    = 4,
    parameter int unsigned STEP_W    = 16
) (
    input  logic              hclk,
    input  logic              reset_code_rom_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic              halt_req,
    input  logic [31:0]       cpu_pc,
    input  logic              cpu_retired,
    input  logic              cpu_finish,
    output logic [31:0]       imem_data,
    output logic              cpu_halt,
    output logic              rsp_valid,
    output logic [1:0]        rsp_code,
    output logic [3:0]        bp_idx,
    output logic              exit_flag
);

    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned BP_IW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_STEPI  = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_SET_BP = 3'd4;
    localparam logic [2:0] OP_CLR_BP = 3'd5;

    localparam logic [1:0] RSP_DONE  = 2'd0;
    localparam logic [1:0] RSP_BP    = 2'd1;
    localparam logic [1:0] RSP_EXIT  = 2'd2;
    localparam logic [1:0] RSP_ERROR = 2'd3;

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        rom_q [NUM_BYTES];
    logic [31:0]       bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_en_q;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              arm_q, arm_d;
    logic              exit_q, exit_d;
    logic [1:0]        rsp_code_q, rsp_code_d;
    logic [3:0]        bp_idx_q, bp_idx_d;
    logic              load_ok, bp_ok;
    logic              rom_we, bp_we;
    logic              bp_hit;
    logic [3:0]        hit_idx;

    assign load_ok   = 32'(cmd_addr) < NUM_BYTES;
    assign bp_ok     = 32'(cmd_addr) < NUM_BP;
    assign cmd_ready = (state_q == ST_IDLE);
    assign cpu_halt  = !((state_q == ST_RUN) || (state_q == ST_STEP));
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_code  = rsp_code_q;
    assign bp_idx    = bp_idx_q;
    assign exit_flag = exit_q;

    // Little-endian instruction fetch; each byte index wraps at the ROM size.
    always_comb begin
        logic [31:0] base;
        base = 32'(cpu_pc[ADDR_W-1:0]);
        for (int k = 0; k < 4; k++) begin
            imem_data[8*k +: 8] = rom_q[IDX_W'((base + 32'(k)) % NUM_BYTES)];
        end
    end

    // Lowest-numbered enabled breakpoint matching the current PC.
    always_comb begin
        bp_hit  = 1'b0;
        hit_idx = 4'd0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (cpu_pc == bp_addr_q[i])) begin
                bp_hit  = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    // Command decode and run/step termination.
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        arm_d      = arm_q;
        exit_d     = exit_q;
        rsp_code_d = rsp_code_q;
        bp_idx_d   = bp_idx_q;
        rom_we     = 1'b0;
        bp_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d    = ST_RESP;
                    rsp_code_d = RSP_DONE;
                    case (cmd_op)
                        OP_NOP: ;
                        OP_RUN: begin
                            if (exit_q) begin
                                rsp_code_d = RSP_EXIT;
                            end else begin
                                state_d = ST_RUN;
                                arm_d   = 1'b0;
                            end
                        end
                        OP_STEPI: begin
                            if (exit_q) begin
                                rsp_code_d = RSP_EXIT;
                            end else begin
                                state_d    = ST_STEP;
                                step_cnt_d = (cmd_data[STEP_W-1:0] == '0) ? STEP_ONE
                                                                         : cmd_data[STEP_W-1:0];
                            end
                        end
                        OP_LOAD: begin
                            if (load_ok) rom_we = 1'b1;
                            else         rsp_code_d = RSP_ERROR;
                        end
                        OP_SET_BP, OP_CLR_BP: begin
                            if (bp_ok) bp_we = 1'b1;
                            else       rsp_code_d = RSP_ERROR;
                        end
                        default: rsp_code_d = RSP_ERROR;
                    endcase
                end
            end
            ST_RUN: begin
                // Arming on the first retire lets a resume step off a breakpoint PC.
                if (cpu_retired) arm_d = 1'b1;
                if (cpu_finish) begin
                    exit_d     = 1'b1;
                    rsp_code_d = RSP_EXIT;
                    state_d    = ST_RESP;
                end else if (arm_q && bp_hit) begin
                    rsp_code_d = RSP_BP;
                    bp_idx_d   = hit_idx;
                    state_d    = ST_RESP;
                end else if (halt_req) begin
                    rsp_code_d = RSP_DONE;
                    state_d    = ST_RESP;
                end
            end
            ST_STEP: begin
                if (cpu_retired) step_cnt_d = step_cnt_q - STEP_ONE;
                if (cpu_finish) begin
                    exit_d     = 1'b1;
                    rsp_code_d = RSP_EXIT;
                    state_d    = ST_RESP;
                end else if ((cpu_retired && (step_cnt_q == STEP_ONE)) || halt_req) begin
                    rsp_code_d = RSP_DONE;
                    state_d    = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state_q    <= ST_IDLE;
            step_cnt_q <= '0;
            arm_q      <= 1'b0;
            exit_q     <= 1'b0;
            rsp_code_q <= RSP_DONE;
            bp_idx_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            arm_q      <= arm_d;
            exit_q     <= exit_d;
            rsp_code_q <= rsp_code_d;
            bp_idx_q   <= bp_idx_d;
        end
    end

    // Code ROM: erased to 0xFF on reset, byte-written by LOAD.
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            for (int i = 0; i < int'(NUM_BYTES); i++) rom_q[i] <= 8'hFF;
        end else if (rom_we) begin
            rom_q[IDX_W'(cmd_addr)] <= cmd_data[7:0];
        end
    end

    // Breakpoint table; CLR_BP also rewrites the address slot.
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            bp_en_q <= '0;
            for (int i = 0; i < int'(NUM_BP); i++) bp_addr_q[i] <= 32'd0;
        end else if (bp_we) begin
            bp_addr_q[BP_IW'(cmd_addr)] <= cmd_data;
            bp_en_q[BP_IW'(cmd_addr)]   <= (cmd_op == OP_SET_BP);
        end
    end

endmodule
